pc_update_unit: RTL and testbench

//  Program-counter stage fed by the PC-source mux: holds PC and EPC and decides

---
 rtl/pc_update_if.sv | 37 +++
 rtl/pc_update_unit.sv | 109 ++++++++++
 tb/tb_pc_update_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_update_if.sv
// PC update bundle: PC-source mux, ALU flags and control-unit requests in;
// PC, EPC, load/trap status and optional PC history read port out.
interface pc_update_if #(
  parameter int HIST_DEPTH = 4
);
  localparam int IW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

  logic [31:0]   pc_next;
  logic          pc_write;
  logic          pc_write_cond;
  logic [1:0]    branch_type;
  logic          alu_zero;
  logic          alu_neg;
  logic          epc_write;
  logic          exc_ack;
  logic [IW-1:0] hist_idx;
  logic [31:0]   pc_out;
  logic [31:0]   epc_out;
  logic          pc_loaded;
  logic          misalign_exc;
  logic          in_trap;
  logic [31:0]   hist_pc;

  modport master (
    output pc_next, pc_write, pc_write_cond, branch_type,
    output alu_zero, alu_neg, epc_write, exc_ack, hist_idx,
    input  pc_out, epc_out, pc_loaded, misalign_exc,
    input  in_trap, hist_pc
  );

  modport slave (
    input  pc_next, pc_write, pc_write_cond, branch_type,
    input  alu_zero, alu_neg, epc_write, exc_ack, hist_idx,
    output pc_out, epc_out, pc_loaded, misalign_exc,
    output in_trap, hist_pc
  );
endinterface

// File: rtl/pc_update_unit.sv
// PC/EPC register stage with branch resolve, misalign trap FSM (RUN/TRAP)
// and optional PC history buffer (define PC_HIST_EN). Ports: clk, reset_n, bus.
module pc_update_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          CHECK_ALIGN = 1'b1,
  parameter int          HIST_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  pc_update_if.slave   bus
);
  localparam int IW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_TRAP = 1'b1;

  logic [0:0]  state;
  logic [31:0] pc;
  logic [31:0] epc;
  logic        loaded;
  logic        exc;
  logic        cond;
  logic        take;
  logic        bad;
  logic        load_en;
  logic        trap_en;
  logic [31:0] pc_m4;

  always_comb begin
    cond = 1'b0;
    unique case (bus.branch_type)
      2'd0: cond = bus.alu_zero;
      2'd1: cond = !bus.alu_zero;
      2'd2: cond = bus.alu_neg | bus.alu_zero;
      2'd3: cond = !bus.alu_neg & !bus.alu_zero;
      default: cond = 1'b0;
    endcase
  end

  assign take  = bus.pc_write | (bus.pc_write_cond & cond);
  assign bad   = CHECK_ALIGN & (bus.pc_next[1:0] != 2'b00);
  assign pc_m4 = pc - 32'd4;

  // In TRAP only an aligned unconditional write (handler vector) loads.
  always_comb begin
    load_en = 1'b0;
    trap_en = 1'b0;
    unique case (1'b1)
      (state == S_RUN): begin
        load_en = take & !bad;
        trap_en = take & bad;
      end
      (state == S_TRAP): begin
        load_en = bus.pc_write & !bad;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_RUN;
      pc     <= RESET_PC;
      epc    <= 32'd0;
      loaded <= 1'b0;
      exc    <= 1'b0;
    end else begin
      loaded <= load_en;
      exc    <= trap_en;
      if (load_en) pc <= bus.pc_next;
      if (state == S_RUN) begin
        if (trap_en || bus.epc_write) epc <= pc_m4;
        if (trap_en) state <= S_TRAP;
      end else if (bus.exc_ack) begin
        state <= S_RUN;
      end
    end
  end

  assign bus.pc_out       = pc;
  assign bus.epc_out      = epc;
  assign bus.pc_loaded    = loaded;
  assign bus.misalign_exc = exc;
  assign bus.in_trap      = (state == S_TRAP);

`ifdef PC_HIST_EN
  logic [31:0]   hist [HIST_DEPTH];
  logic [IW-1:0] wptr;
  logic [IW-1:0] ridx;

  // wptr is the next slot; newest entry sits at wptr-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= 32'd0;
    end else if (load_en) begin
      hist[wptr] <= pc;
      wptr       <= wptr + IW'(1);
    end
  end

  assign ridx        = wptr - IW'(1) - bus.hist_idx;
  assign bus.hist_pc = hist[ridx];
`else
  logic unused_idx;
  assign unused_idx  = ^bus.hist_idx;
  assign bus.hist_pc = 32'd0;
`endif
endmodule

// File: tb/tb_pc_update_unit.sv
// Directed bench for pc_update_unit with an expected-value queue.
// Define PC_HIST_EN to also exercise the history buffer.
module tb_pc_update_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pc_update_if #(.HIST_DEPTH(4)) bus ();

  pc_update_unit #(
    .RESET_PC(32'h0), .CHECK_ALIGN(1'b1), .HIST_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] v;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic push(input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    sb_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s queue empty got %h", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s got %h exp %h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic exp_all(input logic [31:0] pc, input logic [31:0] epc,
                         input bit ld, input bit ex, input bit tr);
    push("pc_out", pc);
    push("epc_out", epc);
    push("pc_loaded", {31'd0, ld});
    push("misalign_exc", {31'd0, ex});
    push("in_trap", {31'd0, tr});
  endtask

  task automatic chk_all();
    chk("pc_out", bus.pc_out);
    chk("epc_out", bus.epc_out);
    chk("pc_loaded", {31'd0, bus.pc_loaded});
    chk("misalign_exc", {31'd0, bus.misalign_exc});
    chk("in_trap", {31'd0, bus.in_trap});
  endtask

  task automatic drv(input bit pw, input bit pwc, input logic [1:0] bt,
                     input bit z, input bit n, input bit ew,
                     input bit ack, input logic [31:0] nx);
    bus.pc_write      = pw;
    bus.pc_write_cond = pwc;
    bus.branch_type   = bt;
    bus.alu_zero      = z;
    bus.alu_neg       = n;
    bus.epc_write     = ew;
    bus.exc_ack       = ack;
    bus.pc_next       = nx;
  endtask

  task automatic idle();
    drv(0, 0, 2'd0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [31:0] pc, input logic [31:0] epc,
                      input bit ld, input bit ex, input bit tr);
    exp_all(pc, epc, ld, ex, tr);
    tick();
    chk_all();
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
  endtask

  initial begin
    idle();
    bus.hist_idx = '0;
    #2;
    exp_all(32'h0, 32'h0, 0, 0, 0);
    chk_all();
    #10 reset_n = 1'b1;

    // load 0x40, then misaligned target -> trap, then reset mid-trap
    drv(1, 0, 2'd0, 0, 0, 0, 0, 32'h40);
    step(32'h40, 32'h0, 1, 0, 0);
    drv(1, 0, 2'd0, 0, 0, 0, 0, 32'h41);
    step(32'h40, 32'h3C, 0, 1, 1);
    idle();
    async_reset();
    exp_all(32'h0, 32'h0, 0, 0, 0);
    chk_all();
    #2 reset_n = 1'b1;

    // epc capture at PC 0 wraps
    drv(0, 0, 2'd0, 0, 0, 1, 0, 32'h0);
    step(32'h0, 32'hFFFF_FFFC, 0, 0, 0);

    // unconditional load, 1-cycle pulse
    drv(1, 0, 2'd0, 0, 0, 0, 0, 32'h4);
    step(32'h4, 32'hFFFF_FFFC, 1, 0, 0);
    idle();
    step(32'h4, 32'hFFFF_FFFC, 0, 0, 0);

    // BEQ taken / not taken
    drv(0, 1, 2'd0, 1, 0, 0, 0, 32'h20);
    step(32'h20, 32'hFFFF_FFFC, 1, 0, 0);
    drv(0, 1, 2'd0, 0, 0, 0, 0, 32'h30);
    step(32'h20, 32'hFFFF_FFFC, 0, 0, 0);
    // BNE, BLE taken, BLE not taken
    drv(0, 1, 2'd1, 0, 0, 0, 0, 32'h24);
    step(32'h24, 32'hFFFF_FFFC, 1, 0, 0);
    drv(0, 1, 2'd2, 0, 1, 0, 0, 32'h28);
    step(32'h28, 32'hFFFF_FFFC, 1, 0, 0);
    drv(0, 1, 2'd2, 0, 0, 0, 0, 32'h2C);
    step(32'h28, 32'hFFFF_FFFC, 0, 0, 0);
    // BGT taken / not taken
    drv(0, 1, 2'd3, 0, 0, 0, 0, 32'h100);
    step(32'h100, 32'hFFFF_FFFC, 1, 0, 0);
    drv(0, 1, 2'd3, 0, 1, 0, 0, 32'h200);
    step(32'h100, 32'hFFFF_FFFC, 0, 0, 0);
    // pc_write wins over a false condition
    drv(1, 1, 2'd0, 0, 0, 0, 0, 32'h10);
    step(32'h10, 32'hFFFF_FFFC, 1, 0, 0);

    // misaligned trap; auto-capture beats epc_write
    drv(1, 0, 2'd0, 0, 0, 1, 0, 32'h22);
    step(32'h10, 32'h0C, 0, 1, 1);
    idle();
    step(32'h10, 32'h0C, 0, 0, 1);
    // in TRAP: cond branch and epc_write ignored
    drv(0, 1, 2'd0, 1, 0, 1, 0, 32'h50);
    step(32'h10, 32'h0C, 0, 0, 1);
    // in TRAP: misaligned write ignored, no new exception
    drv(1, 0, 2'd0, 0, 0, 0, 0, 32'h8002);
    step(32'h10, 32'h0C, 0, 0, 1);
    drv(1, 0, 2'd0, 0, 0, 0, 0, 32'h8000);
    step(32'h8000, 32'h0C, 1, 0, 1);
    // ack with same-cycle load
    drv(1, 0, 2'd0, 0, 0, 0, 1, 32'h8004);
    step(32'h8004, 32'h0C, 1, 0, 0);

    // top-of-space wrap
    drv(1, 0, 2'd0, 0, 0, 0, 0, 32'hFFFF_FFFC);
    step(32'hFFFF_FFFC, 32'h0C, 1, 0, 0);
    drv(1, 0, 2'd0, 0, 0, 0, 0, 32'h0);
    step(32'h0, 32'h0C, 1, 0, 0);
    idle();

`ifdef PC_HIST_EN
    async_reset();
    #2 reset_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      drv(1, 0, 2'd0, 0, 0, 0, 0, 32'(4 * i));
      tick();
    end
    idle();
    push("hist0", 32'h10);
    push("hist1", 32'h0C);
    push("hist2", 32'h08);
    push("hist3", 32'h04);
    for (int i = 0; i < 4; i++) begin
      bus.hist_idx = 2'(i);
      #1;
      chk("hist_pc", bus.hist_pc);
    end
`else
    push("hist_off", 32'h0);
    bus.hist_idx = 2'd2;
    #1;
    chk("hist_pc", bus.hist_pc);
`endif

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL leftover %0d queued expects", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
